// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - multi-cycle MSB-first magnitude comparator
// Scans DIGIT bits per cycle with early exit; signed mode maps to offset binary.
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_eq_b,
  output logic             a_ls_b,
  output logic             a_gt_b
);

  localparam int NSTEP = WIDTH / DIGIT;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  localparam logic [CW-1:0]    LAST_STEP = CW'(NSTEP - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sa, sa_n, sb, sb_n;
  logic             busy_n, done_n, eq_n, ls_n, gt_n;
  logic [DIGIT-1:0] da, db;

  assign da = sa[WIDTH-1 -: DIGIT];
  assign db = sb[WIDTH-1 -: DIGIT];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      sa     <= '0;
      sb     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      a_eq_b <= 1'b0;
      a_ls_b <= 1'b0;
      a_gt_b <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sa     <= sa_n;
      sb     <= sb_n;
      busy   <= busy_n;
      done   <= done_n;
      a_eq_b <= eq_n;
      a_ls_b <= ls_n;
      a_gt_b <= gt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sa_n    = sa;
    sb_n    = sb;
    busy_n  = busy;
    done_n  = 1'b0;
    eq_n    = a_eq_b;
    ls_n    = a_ls_b;
    gt_n    = a_gt_b;
    unique case (state)
      IDLE: begin
        if (start) begin
          // Flipping both MSBs turns a two's-complement order into an unsigned one.
          sa_n    = signed_mode ? (a ^ MSB_MASK) : a;
          sb_n    = signed_mode ? (b ^ MSB_MASK) : b;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (da != db || cnt == LAST_STEP) begin
          gt_n    = (da > db);
          ls_n    = (da < db);
          eq_n    = (da == db);
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          sa_n  = sa << DIGIT;
          sb_n  = sb << DIGIT;
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb/tb_seq_magnitude_comparator.sv - directed and swept checks of seq_magnitude_comparator
module tb_seq_magnitude_comparator;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic signed_mode = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic busy, done, a_eq_b, a_ls_b, a_gt_b;

  logic start_s = 1'b0;
  logic sm_s = 1'b0;
  logic [7:0] a_s = '0, b_s = '0;
  logic busy1, done1, eq1, ls1, gt1;
  logic busy2, done2, eq2, ls2, gt2;
  logic busy8, done8, eq8, ls8, gt8;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] EQ = 3'b001, LS = 3'b010, GT = 3'b100;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy), .done(done), .a_eq_b(a_eq_b), .a_ls_b(a_ls_b), .a_gt_b(a_gt_b));

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(1)) dut_d1 (
    .clk(clk), .reset(reset), .start(start_s), .signed_mode(sm_s), .a(a_s), .b(b_s),
    .busy(busy1), .done(done1), .a_eq_b(eq1), .a_ls_b(ls1), .a_gt_b(gt1));

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) dut_d2 (
    .clk(clk), .reset(reset), .start(start_s), .signed_mode(sm_s), .a(a_s), .b(b_s),
    .busy(busy2), .done(done2), .a_eq_b(eq2), .a_ls_b(ls2), .a_gt_b(gt2));

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(8)) dut_d8 (
    .clk(clk), .reset(reset), .start(start_s), .signed_mode(sm_s), .a(a_s), .b(b_s),
    .busy(busy8), .done(done8), .a_eq_b(eq8), .a_ls_b(ls8), .a_gt_b(gt8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic sm);
    a = av;
    b = bv;
    signed_mode = sm;
    start = 1'b1;
  endtask

  // Called in the start cycle; returns in the done cycle.
  task automatic collect(input string tag, input logic [2:0] exp_flags, input int exp_lat);
    int lat;
    tick();
    start = 1'b0;
    a = 16'hDEAD;
    b = 16'hBEEF;
    lat = 1;
    if (exp_lat > 1) check({tag, "_busy1"}, 32'(busy), 32'd1);
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_flags"}, {a_gt_b, a_ls_b, a_eq_b}, exp_flags);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  function automatic int first_diff(input logic [7:0] x, input int d);
    logic [7:0] mask;
    mask = 8'((1 << d) - 1);
    for (int i = 1; i <= 8 / d; i++)
      if (((x >> (8 - i * d)) & mask) != 0) return i;
    return 8 / d;
  endfunction

  initial begin
    int lat1, lat2, lat8;
    logic [2:0] f1, f2, f8, ef;

    tick();
    tick();
    check("reset_outputs", {busy, done, a_eq_b, a_ls_b, a_gt_b}, 5'b0);
    check("reset_sweep", {busy1, done1, eq1, busy8, done8, gt8}, 6'b0);
    reset = 1'b0;
    tick();

    launch(16'h1234, 16'h1234, 1'b0);
    collect("eq_full", EQ, 5);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("flags_hold", {a_gt_b, a_ls_b, a_eq_b}, EQ);

    launch(16'hA000, 16'h1000, 1'b0);
    collect("gt_early", GT, 2);
    tick();
    launch(16'h0005, 16'h0007, 1'b0);
    collect("ls_last_digit", LS, 5);
    tick();
    launch(16'hFFFF, 16'h0001, 1'b1);
    collect("signed_m1_lt_1", LS, 2);
    tick();
    launch(16'hFFFF, 16'h0001, 1'b0);
    collect("unsigned_ffff_gt_1", GT, 2);
    tick();
    launch(16'h8000, 16'h7FFF, 1'b1);
    collect("signed_min_lt_max", LS, 2);
    tick();

    // Second start while busy must be ignored.
    launch(16'h0000, 16'h0000, 1'b0);
    tick();
    start = 1'b0;
    tick();
    launch(16'h0001, 16'h0000, 1'b0);
    tick();
    start = 1'b0;
    tick();
    tick();
    check("ignore_start_done", 32'(done), 32'd1);
    check("ignore_start_flags", {a_gt_b, a_ls_b, a_eq_b}, EQ);
    tick();
    check("ignore_start_idle", {busy, done}, 2'b00);

    // Back-to-back: new start in the done cycle.
    launch(16'hA000, 16'h1000, 1'b0);
    collect("b2b_first", GT, 2);
    launch(16'h0001, 16'h0002, 1'b0);
    collect("b2b_second", LS, 5);
    tick();

    // Reset during SCAN aborts without done.
    launch(16'h1111, 16'h1112, 1'b0);
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("abort_outputs", {busy, done, a_eq_b, a_ls_b, a_gt_b}, 5'b0);
    reset = 1'b0;
    tick();
    check("abort_no_done", {busy, done}, 2'b00);
    launch(16'h1111, 16'h1112, 1'b0);
    collect("after_abort", LS, 5);
    tick();

    // Reset wins over start.
    reset = 1'b1;
    launch(16'h0001, 16'h0000, 1'b0);
    tick();
    start = 1'b0;
    reset = 1'b0;
    check("reset_beats_start", {busy, done, a_gt_b}, 3'b000);
    tick();
    check("reset_beats_start_idle", 32'(busy), 32'd0);

    // Sweep WIDTH=8 with DIGIT=1,2,8 on shared random operands.
    for (int iter = 0; iter < 2000; iter++) begin
      sm_s = (iter >= 1000);
      a_s = 8'($urandom);
      b_s = (iter % 8 == 0) ? a_s : 8'($urandom);
      if (sm_s) ef = ($signed(a_s) > $signed(b_s)) ? GT : ($signed(a_s) < $signed(b_s)) ? LS : EQ;
      else      ef = (a_s > b_s) ? GT : (a_s < b_s) ? LS : EQ;
      start_s = 1'b1;
      lat1 = 0; lat2 = 0; lat8 = 0;
      f1 = '0; f2 = '0; f8 = '0;
      tick();
      start_s = 1'b0;
      for (int c = 1; c <= 9; c++) begin
        if (done1 && lat1 == 0) begin lat1 = c + 1; f1 = {gt1, ls1, eq1}; end
        if (done2 && lat2 == 0) begin lat2 = c + 1; f2 = {gt2, ls2, eq2}; end
        if (done8 && lat8 == 0) begin lat8 = c + 1; f8 = {gt8, ls8, eq8}; end
        if (c < 9) tick();
      end
      // lat values above are cycle index + 1; expected = first_diff + 2.
      check("sweep_d1_lat", lat1, first_diff(a_s ^ b_s, 1) + 2);
      check("sweep_d2_lat", lat2, first_diff(a_s ^ b_s, 2) + 2);
      check("sweep_d8_lat", lat8, first_diff(a_s ^ b_s, 8) + 2);
      check("sweep_d1_flags", f1, ef);
      check("sweep_d2_flags", f2, ef);
      check("sweep_d8_flags", f8, ef);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
